// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the SRAM access controller.
// Holds the controller state encoding, default geometry and the response record.
package sram_ctrl_pkg;

    localparam int unsigned DEF_ROWS = 16;
    localparam int unsigned DEF_COLS = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        LOAD    = 3'd2,
        WRITE   = 3'd3,
        READ    = 3'd4,
        WAIT_RD = 3'd5,
        RESP    = 3'd6
    } ctrl_state_e;

    // Completed-request response at the default word width.
    typedef struct packed {
        logic                we;
        logic                err;
        logic [DEF_COLS-1:0] rdata;
    } rsp_t;

endpackage

// File: rtl/sram_access_ctrl_if.sv
// Request/response bus of the SRAM access controller.
// master: requester (drives req_*, receives req_ready and rsp_*).
// slave : controller (receives req_*, drives req_ready and rsp_*).
interface sram_access_ctrl_if #(
    parameter int unsigned AW   = 4,
    parameter int unsigned COLS = 8
) ();
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [AW-1:0]   req_addr;
    logic [COLS-1:0] req_wdata;
    logic            rsp_valid;
    logic            rsp_we;
    logic            rsp_err;
    logic [COLS-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_we, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_we, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/sram_ser_piso.sv
// Parallel-in serial-out shifter feeding the SRAM serial write port, MSB first.
// Ports: clk, arst_n; start (load word and begin), word (parallel data);
// serial_in/shift (registered serial bit and enable), done (high during the last shift cycle).
module sram_ser_piso #(
    parameter int unsigned COLS         = 8,
    parameter int unsigned SHIFT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            start,
    input  logic [COLS-1:0] word,
    output logic            serial_in,
    output logic            shift,
    output logic            done
);
    localparam int unsigned BW = $clog2(COLS);
    localparam int unsigned HW = $clog2(SHIFT_CYCLES) + 1;

    logic [COLS-1:0] sreg;
    logic [BW-1:0]   idx, idx_n;
    logic [HW-1:0]   hold, hold_n;
    logic            shift_n, ser_n;

    // Next bit index / hold count; each bit is held SHIFT_CYCLES cycles.
    always_comb begin
        idx_n   = idx;
        hold_n  = hold;
        shift_n = shift;
        ser_n   = serial_in;
        if (start) begin
            idx_n   = BW'(COLS - 1);
            hold_n  = '0;
            shift_n = 1'b1;
            ser_n   = word[COLS-1];
        end else if (shift) begin
            if (hold == HW'(SHIFT_CYCLES - 1)) begin
                hold_n = '0;
                if (idx == '0) begin
                    shift_n = 1'b0;
                    ser_n   = 1'b0;
                end else begin
                    idx_n = idx - BW'(1);
                    ser_n = sreg[idx_n];
                end
            end else begin
                hold_n = hold + HW'(1);
            end
        end
    end

    // done is registered from the next-cycle view so it coincides with the final shift cycle.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sreg      <= '0;
            idx       <= '0;
            hold      <= '0;
            shift     <= 1'b0;
            serial_in <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (start) begin
                sreg <= word;
            end
            idx       <= idx_n;
            hold      <= hold_n;
            shift     <= shift_n;
            serial_in <= ser_n;
            done      <= shift_n && (idx_n == '0) && (hold_n == HW'(SHIFT_CYCLES - 1));
        end
    end
endmodule

// File: rtl/sram_access_ctrl.sv
// Sequencing controller in front of the mixed-signal SRAM.
// Ports: clk, arst_n; bus (request/response handshake, slave side);
// serial_in/shift/load/w_en/r_en/addr (registered SRAM controls); data_valid/data_out (SRAM read return).
module sram_access_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ROWS         = DEF_ROWS,
    parameter int unsigned COLS         = DEF_COLS,
    parameter int unsigned SHIFT_CYCLES = 2,
    parameter int unsigned RD_TIMEOUT   = 16,
    localparam int unsigned AW          = $clog2(ROWS)
) (
    input  logic            clk,
    input  logic            arst_n,
    sram_access_ctrl_if.slave bus,
    output logic            serial_in,
    output logic            shift,
    output logic            load,
    output logic            w_en,
    output logic            r_en,
    output logic [AW-1:0]   addr,
    input  logic            data_valid,
    input  logic [COLS-1:0] data_out
);
    localparam int unsigned TW = $clog2(RD_TIMEOUT) + 1;

    localparam logic [2:0] ST_IDLE    = IDLE;
    localparam logic [2:0] ST_SHIFT   = SHIFT;
    localparam logic [2:0] ST_LOAD    = LOAD;
    localparam logic [2:0] ST_WRITE   = WRITE;
    localparam logic [2:0] ST_READ    = READ;
    localparam logic [2:0] ST_WAIT_RD = WAIT_RD;
    localparam logic [2:0] ST_RESP    = RESP;

    logic [2:0]      state, state_n;
    logic [TW-1:0]   tcnt, tcnt_n;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic            accept, in_range, piso_start, piso_done;
    logic            rsp_we_n, rsp_err_n;
    logic [COLS-1:0] rsp_rdata_n;
    logic            req_ready_q, rsp_valid_q, rsp_we_q, rsp_err_q;
    logic [COLS-1:0] rsp_rdata_q;

    assign accept   = bus.req_valid && req_ready_q;
    assign in_range = 32'(bus.req_addr) < ROWS;

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_we    = rsp_we_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign addr          = addr_q;

    sram_ser_piso #(
        .COLS         (COLS),
        .SHIFT_CYCLES (SHIFT_CYCLES)
    ) u_piso (
        .clk       (clk),
        .arst_n    (arst_n),
        .start     (piso_start),
        .word      (bus.req_wdata),
        .serial_in (serial_in),
        .shift     (shift),
        .done      (piso_done)
    );

    // Next state and next response fields; response fields are non-zero only on entry to RESP.
    always_comb begin
        state_n     = state;
        tcnt_n      = tcnt;
        piso_start  = 1'b0;
        rsp_we_n    = 1'b0;
        rsp_err_n   = 1'b0;
        rsp_rdata_n = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!in_range) begin
                        state_n   = ST_RESP;
                        rsp_we_n  = bus.req_we;
                        rsp_err_n = 1'b1;
                    end else if (bus.req_we) begin
                        state_n    = ST_SHIFT;
                        piso_start = 1'b1;
                    end else begin
                        state_n = ST_READ;
                    end
                end
            end
            ST_SHIFT: begin
                if (piso_done) begin
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD:  state_n = ST_WRITE;
            ST_WRITE: begin
                state_n  = ST_RESP;
                rsp_we_n = we_q;
            end
            ST_READ: begin
                state_n = ST_WAIT_RD;
                tcnt_n  = '0;
            end
            ST_WAIT_RD: begin
                if (data_valid) begin
                    state_n     = ST_RESP;
                    rsp_we_n    = we_q;
                    rsp_rdata_n = data_out;
                end else if (tcnt >= TW'(RD_TIMEOUT - 1)) begin
                    state_n   = ST_RESP;
                    rsp_we_n  = we_q;
                    rsp_err_n = 1'b1;
                end else if (tcnt != TW'(RD_TIMEOUT)) begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
            ST_RESP:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= ST_IDLE;
            tcnt  <= '0;
        end else begin
            state <= state_n;
            tcnt  <= tcnt_n;
        end
    end

    // Request capture; addr is held from acceptance until the next acceptance.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            we_q   <= 1'b0;
            addr_q <= '0;
        end else if (accept) begin
            we_q   <= bus.req_we;
            addr_q <= bus.req_addr;
        end
    end

    // Registered outputs decoded from the next state, so strobes are exclusive by construction.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            req_ready_q <= 1'b1;
            load        <= 1'b0;
            w_en        <= 1'b0;
            r_en        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            req_ready_q <= (state_n == ST_IDLE);
            load        <= (state_n == ST_LOAD);
            w_en        <= (state_n == ST_WRITE);
            r_en        <= (state_n == ST_READ);
            rsp_valid_q <= (state_n == ST_RESP);
            rsp_we_q    <= rsp_we_n;
            rsp_err_q   <= rsp_err_n;
            rsp_rdata_q <= rsp_rdata_n;
        end
    end
endmodule

// File: tb/tb_sram_access_ctrl.sv
// Self-checking bench for sram_access_ctrl: a ROWS=16 instance and a ROWS=12 instance,
// table-driven request vectors plus back-to-back and mid-shift reset sequences.
module tb_sram_access_ctrl;
    import sram_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       rv = 1'b0, rwe = 1'b0, dv = 1'b0, sel12 = 1'b0;
    logic [3:0] raddr = '0;
    logic [7:0] rwdata = '0, dout = '0;

    always #5 clk = ~clk;

    sram_access_ctrl_if #(.AW(4), .COLS(8)) bus0 ();
    sram_access_ctrl_if #(.AW(4), .COLS(8)) bus1 ();

    assign bus0.req_valid = rv & ~sel12;
    assign bus0.req_we    = rwe;
    assign bus0.req_addr  = raddr;
    assign bus0.req_wdata = rwdata;
    assign bus1.req_valid = rv & sel12;
    assign bus1.req_we    = rwe;
    assign bus1.req_addr  = raddr;
    assign bus1.req_wdata = rwdata;

    logic       sin0, sh0, ld0, wen0, ren0, sin1, sh1, ld1, wen1, ren1;
    logic [3:0] ad0, ad1;

    sram_access_ctrl #(.ROWS(16), .COLS(8), .SHIFT_CYCLES(2), .RD_TIMEOUT(16)) u_dut (
        .clk(clk), .arst_n(arst_n), .bus(bus0),
        .serial_in(sin0), .shift(sh0), .load(ld0), .w_en(wen0), .r_en(ren0), .addr(ad0),
        .data_valid(dv), .data_out(dout)
    );

    sram_access_ctrl #(.ROWS(12), .COLS(8), .SHIFT_CYCLES(2), .RD_TIMEOUT(16)) u_dut12 (
        .clk(clk), .arst_n(arst_n), .bus(bus1),
        .serial_in(sin1), .shift(sh1), .load(ld1), .w_en(wen1), .r_en(ren1), .addr(ad1),
        .data_valid(dv), .data_out(dout)
    );

    // Outputs of whichever instance the current test addresses.
    logic       o_sin, o_sh, o_ld, o_wen, o_ren, o_rdy, o_rv, o_rwe, o_rerr;
    logic [3:0] o_addr;
    logic [7:0] o_rdata;
    assign o_sin   = sel12 ? sin1 : sin0;
    assign o_sh    = sel12 ? sh1  : sh0;
    assign o_ld    = sel12 ? ld1  : ld0;
    assign o_wen   = sel12 ? wen1 : wen0;
    assign o_ren   = sel12 ? ren1 : ren0;
    assign o_addr  = sel12 ? ad1  : ad0;
    assign o_rdy   = sel12 ? bus1.req_ready : bus0.req_ready;
    assign o_rv    = sel12 ? bus1.rsp_valid : bus0.rsp_valid;
    assign o_rwe   = sel12 ? bus1.rsp_we    : bus0.rsp_we;
    assign o_rerr  = sel12 ? bus1.rsp_err   : bus0.rsp_err;
    assign o_rdata = sel12 ? bus1.rsp_rdata : bus0.rsp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit         sel;
        bit         we;
        logic [3:0] addr;
        logic [7:0] wdata;
        int         dv_k;     // cycle after acceptance carrying data_valid (0 = never)
        logic [7:0] dv_data;
        int         lat;      // cycle of rsp_valid after acceptance
        rsp_t       rsp;
        int         nshift;
        int         ld_c;     // 0 = no pulse expected
        int         wen_c;
        int         ren_c;
    } vec_t;

    function automatic vec_t mk(bit sel, bit we, logic [3:0] a, logic [7:0] wd, int k,
                                logic [7:0] dd, int lat, bit ewe, bit eerr, logic [7:0] erd,
                                int nsh, int ldc, int wenc, int renc);
        vec_t v;
        v.sel = sel; v.we = we; v.addr = a; v.wdata = wd; v.dv_k = k; v.dv_data = dd;
        v.lat = lat; v.rsp.we = ewe; v.rsp.err = eerr; v.rsp.rdata = erd;
        v.nshift = nsh; v.ld_c = ldc; v.wen_c = wenc; v.ren_c = renc;
        return v;
    endfunction

    task automatic run_vec(input int i, input vec_t v);
        int c, rsp_c, nsh, sh_first, ld_c, wen_c, ren_c, ser_bad, ovl, addr_bad, bi;
        logic rwe_s, rerr_s, exp_bit;
        logic [7:0] rdata_s;
        rsp_c = -1; nsh = 0; sh_first = 0; ld_c = 0; wen_c = 0; ren_c = 0;
        ser_bad = 0; ovl = 0; addr_bad = 0; rwe_s = 1'b0; rerr_s = 1'b0; rdata_s = '0;
        @(negedge clk);
        sel12 = v.sel; rv = 1'b1; rwe = v.we; raddr = v.addr; rwdata = v.wdata;
        #1;
        chk($sformatf("v%0d_ready_before", i), 32'(o_rdy), 32'd1);
        @(posedge clk);
        for (c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) rv = 1'b0;
            if (32'(o_sh) + 32'(o_ld) + 32'(o_wen) + 32'(o_ren) > 32'd1) ovl++;
            if (o_sh) begin
                nsh++;
                if (sh_first == 0) sh_first = c;
                bi = 7 - (c - 1) / 2;
                exp_bit = (bi >= 0) ? v.wdata[bi] : 1'b0;
                if (o_sin !== exp_bit) ser_bad++;
            end else if (o_sin !== 1'b0) begin
                ser_bad++;
            end
            if (o_ld) ld_c = c;
            if (o_wen) begin
                wen_c = c;
                if (o_addr !== v.addr) addr_bad++;
            end
            if (o_ren) begin
                ren_c = c;
                if (o_addr !== v.addr) addr_bad++;
            end
            dv = (c == v.dv_k);
            dout = v.dv_data;
            if (o_rv) begin
                rsp_c = c; rwe_s = o_rwe; rerr_s = o_rerr; rdata_s = o_rdata;
                break;
            end
        end
        @(negedge clk);
        dv = 1'b0;
        chk($sformatf("v%0d_ready_after", i), 32'(o_rdy), 32'd1);
        chk($sformatf("v%0d_rsp_cycle", i), 32'(rsp_c), 32'(v.lat));
        chk($sformatf("v%0d_rsp_we", i), 32'(rwe_s), 32'(v.rsp.we));
        chk($sformatf("v%0d_rsp_err", i), 32'(rerr_s), 32'(v.rsp.err));
        chk($sformatf("v%0d_rsp_rdata", i), 32'(rdata_s), 32'(v.rsp.rdata));
        chk($sformatf("v%0d_shift_count", i), 32'(nsh), 32'(v.nshift));
        chk($sformatf("v%0d_shift_first", i), 32'(sh_first), (v.nshift > 0) ? 32'd1 : 32'd0);
        chk($sformatf("v%0d_load_cycle", i), 32'(ld_c), 32'(v.ld_c));
        chk($sformatf("v%0d_wen_cycle", i), 32'(wen_c), 32'(v.wen_c));
        chk($sformatf("v%0d_ren_cycle", i), 32'(ren_c), 32'(v.ren_c));
        chk($sformatf("v%0d_serial_bits", i), 32'(ser_bad), 32'd0);
        chk($sformatf("v%0d_strobe_overlap", i), 32'(ovl), 32'd0);
        chk($sformatf("v%0d_strobe_addr", i), 32'(addr_bad), 32'd0);
    endtask

    vec_t vecs[12];

    initial begin
        int nacc, nrsp, rd_bad, ovl, rdy_bad, quiet_rsp, quiet_rdy;
        int acc[2];
        bit rdy_hist[16];

        //            sel we addr wdata  k  data   lat we err rdata  nsh ld wen ren
        vecs[0]  = mk(0, 1, 3,  8'hA5, 0,  8'h00, 19, 1, 0, 8'h00, 16, 17, 18, 0);
        vecs[1]  = mk(0, 0, 7,  8'h00, 4,  8'h3C, 5,  0, 0, 8'h3C, 0,  0,  0,  1);
        vecs[2]  = mk(0, 0, 5,  8'h00, 0,  8'h00, 18, 0, 1, 8'h00, 0,  0,  0,  1);
        vecs[3]  = mk(0, 1, 15, 8'h00, 0,  8'h00, 19, 1, 0, 8'h00, 16, 17, 18, 0);
        vecs[4]  = mk(0, 1, 0,  8'hFF, 0,  8'h00, 19, 1, 0, 8'h00, 16, 17, 18, 0);
        vecs[5]  = mk(0, 0, 0,  8'h00, 2,  8'h81, 3,  0, 0, 8'h81, 0,  0,  0,  1);
        vecs[6]  = mk(0, 0, 15, 8'h00, 17, 8'h5A, 18, 0, 0, 8'h5A, 0,  0,  0,  1);
        vecs[7]  = mk(0, 0, 2,  8'h00, 18, 8'h77, 18, 0, 1, 8'h00, 0,  0,  0,  1);
        vecs[8]  = mk(0, 0, 4,  8'h00, 1,  8'h11, 18, 0, 1, 8'h00, 0,  0,  0,  1);
        vecs[9]  = mk(1, 1, 13, 8'hA5, 0,  8'h00, 1,  1, 1, 8'h00, 0,  0,  0,  0);
        vecs[10] = mk(1, 0, 12, 8'h00, 0,  8'h00, 1,  0, 1, 8'h00, 0,  0,  0,  0);
        vecs[11] = mk(1, 0, 11, 8'h00, 3,  8'hC3, 4,  0, 0, 8'hC3, 0,  0,  0,  1);

        // Reset values while reset is held.
        @(negedge clk);
        chk("rst_ready", 32'(bus0.req_ready), 32'd1);
        chk("rst_ready12", 32'(bus1.req_ready), 32'd1);
        chk("rst_strobes", {27'd0, sh0, sin0, ld0, wen0, ren0}, 32'd0);
        chk("rst_rsp", {22'd0, bus0.rsp_valid, bus0.rsp_we, bus0.rsp_err, bus0.rsp_rdata}, 32'd0);
        chk("rst_addr", 32'(ad0), 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_vec(i, vecs[i]);
        end

        // Back-to-back reads with req_valid held; data_valid held high throughout.
        @(negedge clk);
        sel12 = 1'b0; rv = 1'b1; rwe = 1'b0; raddr = 4'd1; dv = 1'b1; dout = 8'h42;
        nacc = 0; nrsp = 0; rd_bad = 0; ovl = 0; acc[0] = -1; acc[1] = -1;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            if (nacc >= 2) rv = 1'b0;
            #1;
            rdy_hist[c] = o_rdy;
            if (32'(o_sh) + 32'(o_ld) + 32'(o_wen) + 32'(o_ren) > 32'd1) ovl++;
            if (o_rv) begin
                nrsp++;
                if (o_rdata !== 8'h42 || o_rerr !== 1'b0) rd_bad++;
            end
            if (o_rdy && rv) begin
                if (nacc < 2) acc[nacc] = c;
                nacc++;
            end
        end
        dv = 1'b0;
        rdy_bad = 0;
        if (acc[0] >= 0 && acc[1] > acc[0]) begin
            for (int c = acc[0] + 1; c < acc[1]; c++) if (rdy_hist[c]) rdy_bad++;
        end
        chk("b2b_first_accept", 32'(acc[0]), 32'd0);
        chk("b2b_spacing", 32'(acc[1] - acc[0]), 32'd4);
        chk("b2b_accepts", 32'(nacc), 32'd2);
        chk("b2b_responses", 32'(nrsp), 32'd2);
        chk("b2b_rdata", 32'(rd_bad), 32'd0);
        chk("b2b_ready_low", 32'(rdy_bad), 32'd0);
        chk("b2b_overlap", 32'(ovl), 32'd0);

        // Reset in the middle of a write shift.
        @(negedge clk);
        sel12 = 1'b0; rv = 1'b1; rwe = 1'b1; raddr = 4'd3; rwdata = 8'hA5;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) rv = 1'b0;
        end
        chk("mid_shift_active", {30'd0, o_sh, o_sin}, 32'd3);
        arst_n = 1'b0;
        #1;
        chk("mid_rst_shift", {30'd0, o_sh, o_sin}, 32'd0);
        chk("mid_rst_strobes", {29'd0, o_ld, o_wen, o_ren}, 32'd0);
        chk("mid_rst_addr", 32'(o_addr), 32'd0);
        chk("mid_rst_rsp", 32'(o_rv), 32'd0);
        chk("mid_rst_ready", 32'(o_rdy), 32'd1);
        @(negedge clk);
        arst_n = 1'b1;
        quiet_rsp = 0; quiet_rdy = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (o_rv) quiet_rsp++;
            if (!o_rdy) quiet_rdy++;
        end
        chk("post_rst_no_rsp", 32'(quiet_rsp), 32'd0);
        chk("post_rst_ready", 32'(quiet_rdy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
